// File: rtl/membus_master.sv
// rtl/membus_master.sv - initiator for the 36-bit word memory bus (read, write, read-pause-write)
module membus_master #(
    parameter int TIMEOUT = 100
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [17:0] i_addr,
    input  logic [35:0] i_wdata,
    input  logic        i_wrrs,
    output logic [35:0] o_rdata,
    output logic        o_rdone,
    output logic        o_done,
    output logic        o_nxm,
    output logic        o_busy,
    output logic [17:0] o_address,
    output logic        o_read,
    output logic        o_write,
    output logic [35:0] o_writedata,
    input  logic [35:0] i_readdata,
    input  logic        i_waitrequest
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    // Counter only ever needs to hold TIMEOUT-1; the edge that would reach TIMEOUT aborts instead.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]    state;
    logic          rmw;
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_IDLE;
            rmw         <= 1'b0;
            tmo_cnt     <= '0;
            o_rdata     <= '0;
            o_rdone     <= 1'b0;
            o_done      <= 1'b0;
            o_nxm       <= 1'b0;
            o_busy      <= 1'b0;
            o_address   <= '0;
            o_read      <= 1'b0;
            o_write     <= 1'b0;
            o_writedata <= '0;
        end else begin
            o_rdone <= 1'b0;
            o_done  <= 1'b0;
            o_nxm   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req && (i_rd || i_wr)) begin
                        o_address <= i_addr;
                        rmw       <= i_rd & i_wr;
                        tmo_cnt   <= '0;
                        o_busy    <= 1'b1;
                        if (i_rd) begin
                            state  <= S_READ;
                            o_read <= 1'b1;
                        end else begin
                            o_writedata <= i_wdata;
                            state       <= S_WRITE;
                            o_write     <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (!i_waitrequest) begin
                        o_rdata <= i_readdata;
                        o_rdone <= 1'b1;
                        o_read  <= 1'b0;
                        if (rmw) begin
                            state <= S_PAUSE;
                        end else begin
                            state  <= S_GAP;
                            o_done <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Abandon the whole access, including any pending RMW write.
                        o_rdata <= '0;
                        o_read  <= 1'b0;
                        o_done  <= 1'b1;
                        o_nxm   <= 1'b1;
                        state   <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                S_PAUSE: begin
                    if (i_wrrs) begin
                        o_writedata <= i_wdata;
                        o_write     <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!i_waitrequest) begin
                        o_write <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= S_GAP;
                    end else if (tmo_hit) begin
                        o_write <= 1'b0;
                        o_done  <= 1'b1;
                        o_nxm   <= 1'b1;
                        state   <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    // One idle cycle with strobes low so responder delay counters re-arm.
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    o_read  <= 1'b0;
                    o_write <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
